// File: rtl/if_id_skid_stage.sv
// Fetch-to-decode pipeline stage. Holds up to two entries (head + skid) behind a
// valid/ready handshake. in_ready is a flop, so out_ready has no combinational
// path to in_ready. Register/CSR address fields are extracted when an entry is
// captured. ECALL/EBREAK entries are flagged so they stay committable when they
// carry an exception.
module if_id_skid_stage #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ILEN    = 32,
  parameter int unsigned ECODE_W = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_pc,
  input  logic [XLEN-1:0]    in_npc,
  input  logic [ILEN-1:0]    in_inst,
  input  logic               in_except,
  input  logic [ECODE_W-1:0] in_ecode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_pc,
  output logic [XLEN-1:0]    out_npc,
  output logic [ILEN-1:0]    out_inst,
  output logic               out_except,
  output logic [ECODE_W-1:0] out_ecode,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_rs1,
  output logic [4:0]         out_rs2,
  output logic [11:0]        out_csr,
  output logic               out_commit_ok,
  output logic               out_sys,
  output logic [1:0]         occupancy,
  output logic [CNT_W-1:0]   stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    npc;
    logic [ILEN-1:0]    inst;
    logic               except;
    logic [ECODE_W-1:0] ecode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [11:0]        csr;
  } entry_t;

  state_e           state_q, state_d;
  entry_t           head_q, head_d;
  entry_t           skid_q, skid_d;
  entry_t           cap;
  logic             in_ready_q;
  logic [CNT_W-1:0] stall_q;
  logic             accept;
  logic             pop;
  logic [31:0]      head_inst32;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  // Build the captured entry; an excepting fetch has no meaningful npc or fields
  always_comb begin
    cap        = '0;
    cap.pc     = in_pc;
    cap.inst   = in_inst;
    cap.except = in_except;
    cap.ecode  = in_ecode;
    if (!in_except) begin
      cap.npc = in_npc;
      cap.rd  = in_inst[11:7];
      cap.rs1 = in_inst[19:15];
      cap.rs2 = in_inst[24:20];
      cap.csr = in_inst[31:20];
    end
  end

  // Next-state and payload movement; flush empties and zeroes everything
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            head_d  = cap;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head_d = cap;
          end else if (accept) begin
            skid_d  = cap;
            state_d = FULL;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State, payload and registered in_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Saturating count of cycles the decoder holds off a valid head; only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && !(&stall_q)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign head_inst32   = head_q.inst[31:0];
  assign out_pc        = head_q.pc;
  assign out_npc       = head_q.npc;
  assign out_inst      = head_q.inst;
  assign out_except    = head_q.except;
  assign out_ecode     = head_q.ecode;
  assign out_rd        = head_q.rd;
  assign out_rs1       = head_q.rs1;
  assign out_rs2       = head_q.rs2;
  assign out_csr       = head_q.csr;
  assign out_sys       = (head_inst32 == 32'h0000_0073) || (head_inst32 == 32'h0010_0073);
  assign out_commit_ok = ~head_q.except | out_sys;
  assign occupancy     = state_q;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: a queue-based model of the stage is checked on every
// falling edge, with directed scenarios pinned by literal expectations.
module tb_if_id_skid_stage;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;
  localparam int unsigned EW   = 4;
  localparam int unsigned CW   = 4;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, in_except, out_valid, out_ready;
  logic [XLEN-1:0] in_pc, in_npc, out_pc, out_npc;
  logic [ILEN-1:0] in_inst, out_inst;
  logic [EW-1:0]   in_ecode, out_ecode;
  logic            out_except, out_commit_ok, out_sys;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [11:0]     out_csr;
  logic [1:0]      occupancy;
  logic [CW-1:0]   stall_cnt;

  if_id_skid_stage #(.XLEN(XLEN), .ILEN(ILEN), .ECODE_W(EW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_npc(in_npc), .in_inst(in_inst),
    .in_except(in_except), .in_ecode(in_ecode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_npc(out_npc), .out_inst(out_inst),
    .out_except(out_except), .out_ecode(out_ecode),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_csr(out_csr),
    .out_commit_ok(out_commit_ok), .out_sys(out_sys),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] npc;
    logic [31:0] inst;
    logic        ex;
    logic [3:0]  ec;
  } ent_t;

  ent_t q[$];
  bit   zeroed = 1'b0;
  bit   armed  = 1'b0;
  int   mstall = 0;
  int   nchk   = 0;
  int   nerr   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare DUT outputs against the model's view of the queue
  task automatic check_model();
    ent_t e;
    logic sys;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    chk("stall_cnt", 64'(stall_cnt), 64'(mstall));
    if (q.size() > 0) begin
      e   = q[0];
      sys = (e.inst == 32'h0000_0073) || (e.inst == 32'h0010_0073);
      chk("out_pc", out_pc, e.pc);
      chk("out_npc", out_npc, e.ex ? 64'd0 : e.npc);
      chk("out_inst", 64'(out_inst), 64'(e.inst));
      chk("out_except", 64'(out_except), 64'(e.ex));
      chk("out_ecode", 64'(out_ecode), 64'(e.ec));
      chk("out_rd", 64'(out_rd), e.ex ? 64'd0 : 64'((e.inst >> 7) & 32'h1f));
      chk("out_rs1", 64'(out_rs1), e.ex ? 64'd0 : 64'((e.inst >> 15) & 32'h1f));
      chk("out_rs2", 64'(out_rs2), e.ex ? 64'd0 : 64'((e.inst >> 20) & 32'h1f));
      chk("out_csr", 64'(out_csr), e.ex ? 64'd0 : 64'(e.inst >> 20));
      chk("out_sys", 64'(out_sys), 64'(sys));
      chk("out_commit_ok", 64'(out_commit_ok), 64'(!e.ex || sys));
    end else if (zeroed) begin
      chk("zero_pc", out_pc, 64'd0);
      chk("zero_inst", 64'(out_inst), 64'd0);
      chk("zero_npc", out_npc, 64'd0);
      chk("zero_commit_ok", 64'(out_commit_ok), 64'd1);
      chk("zero_sys", 64'(out_sys), 64'd0);
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge
  task automatic tick();
    bit   ov, ir;
    ent_t c;
    @(negedge clk);
    if (armed) check_model();
    @(posedge clk);
    if (rst) begin
      q.delete();
      zeroed = 1'b1;
      mstall = 0;
      armed  = 1'b1;
    end else if (armed) begin
      ov = (q.size() > 0);
      ir = (q.size() < 2);
      if (ov && !out_ready && mstall < 15) mstall++;
      if (flush) begin
        q.delete();
        zeroed = 1'b1;
      end else begin
        if (ov && out_ready) void'(q.pop_front());
        if (in_valid && ir) begin
          c.pc = in_pc; c.npc = in_npc; c.inst = in_inst; c.ex = in_except; c.ec = in_ecode;
          q.push_back(c);
          zeroed = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic present(input logic [63:0] pc, input logic [63:0] npc,
                         input logic [31:0] inst, input logic ex, input logic [3:0] ec);
    in_valid = 1'b1; in_pc = pc; in_npc = npc; in_inst = inst; in_except = ex; in_ecode = ec;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_npc = '0; in_inst = '0; in_except = 1'b0; in_ecode = '0;
    do_reset();

    // Reset values
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_commit_ok", 64'(out_commit_ok), 64'd1);

    // Streaming: 8 entries with out_ready held high
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      present(64'h1000 + 64'(4 * k), 64'h1004 + 64'(4 * k), 32'h0000_0013, 1'b0, 4'd0);
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_pc", out_pc, 64'h1000 + 64'(4 * k));
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_stall", 64'(stall_cnt), 64'd0);

    // Skid: A accepted, out_ready drops while B presented, held low
    do_reset();
    out_ready = 1'b1;
    present(64'h2000, 64'h2004, 32'h0000_0013, 1'b0, 4'd0);
    tick();
    out_ready = 1'b0;
    present(64'h2004, 64'h2008, 32'h0000_0113, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    chk("skid_occ", 64'(occupancy), 64'd2);
    chk("skid_in_ready", 64'(in_ready), 64'd0);
    chk("skid_head_pc", out_pc, 64'h2000);
    tick(); tick();
    chk("skid_stall3", 64'(stall_cnt), 64'd3);
    tick();
    chk("skid_stall4", 64'(stall_cnt), 64'd4);
    out_ready = 1'b1;
    tick();
    chk("skid_b_pc", out_pc, 64'h2004);
    chk("skid_b_occ", 64'(occupancy), 64'd1);
    chk("skid_b_stall", 64'(stall_cnt), 64'd4);
    tick();
    chk("skid_drained", 64'(out_valid), 64'd0);

    // Flush while FULL with a concurrent input and out_ready high
    out_ready = 1'b0;
    present(64'h4000, 64'h4004, 32'h0000_0013, 1'b0, 4'd0); tick();
    present(64'h4004, 64'h4008, 32'h0000_0013, 1'b0, 4'd0); tick();
    chk("flush_pre_occ", 64'(occupancy), 64'd2);
    present(64'h4008, 64'h400c, 32'h0000_0013, 1'b0, 4'd0);
    out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_pc", out_pc, 64'd0);
    tick();

    // Exception on ECALL: still committable
    present(64'h3000, 64'h3004, 32'h0000_0073, 1'b1, 4'd11);
    tick();
    in_valid = 1'b0;
    chk("ecall_sys", 64'(out_sys), 64'd1);
    chk("ecall_commit", 64'(out_commit_ok), 64'd1);
    chk("ecall_npc", out_npc, 64'd0);
    chk("ecall_rd", 64'(out_rd), 64'd0);
    chk("ecall_ecode", 64'(out_ecode), 64'd11);
    tick();

    // Exception on ordinary instruction
    present(64'h3008, 64'h300c, 32'h00A0_0093, 1'b1, 4'd1);
    tick();
    in_valid = 1'b0;
    chk("exc_sys", 64'(out_sys), 64'd0);
    chk("exc_commit", 64'(out_commit_ok), 64'd0);
    chk("exc_fields", {out_rd, out_rs1, out_rs2, out_csr}, 64'd0);
    tick();

    // Field extraction: csrr a0, mcause
    present(64'h3010, 64'h3014, 32'h3420_2573, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    chk("csrr_rd", 64'(out_rd), 64'd10);
    chk("csrr_rs1", 64'(out_rs1), 64'd0);
    chk("csrr_csr", 64'(out_csr), 64'h342);
    chk("csrr_commit", 64'(out_commit_ok), 64'd1);
    tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      case ($urandom_range(0, 7))
        0:       ins = 32'h0000_0073;
        1:       ins = 32'h0010_0073;
        default: ins = $urandom;
      endcase
      present({$urandom, $urandom}, {$urandom, $urandom}, ins,
              ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0;

    // Reset while FULL
    do_reset();
    out_ready = 1'b0;
    present(64'h5000, 64'h5004, 32'h0000_0013, 1'b0, 4'd0); tick();
    present(64'h5004, 64'h5008, 32'h0000_0013, 1'b0, 4'd0); tick();
    chk("rstfull_pre_occ", 64'(occupancy), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rstfull_valid", 64'(out_valid), 64'd0);
    chk("rstfull_in_ready", 64'(in_ready), 64'd1);
    chk("rstfull_occ", 64'(occupancy), 64'd0);
    chk("rstfull_stall", 64'(stall_cnt), 64'd0);
    chk("rstfull_pc", out_pc, 64'd0);
    chk("rstfull_commit", 64'(out_commit_ok), 64'd1);

    // Stall counter saturation
    present(64'h6000, 64'h6004, 32'h0000_0013, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 20; n++) tick();
    chk("stall_sat", 64'(stall_cnt), 64'd15);
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
